// File: rtl/ddr3_tg_pkg.sv
// ddr3_tg_pkg: shared types and constants for the DDR3 Avalon traffic generator.
package ddr3_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAL,
        WRITE,
        READ,
        DONE,
        FAIL
    } tg_state_t;

    // x^32 + x^22 + x^2 + x + 1 as a right-shifting Galois feedback mask
    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;
    localparam int          ERR_CNT_W         = 16;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/ddr3_avl_traffic_gen_if.sv
// ddr3_avl_traffic_gen_if: Avalon-MM local-port bundle between the traffic generator
// (master) and the DDR3 EMIF (slave).
interface ddr3_avl_traffic_gen_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64
);
    logic                  ready;
    logic [ADDR_W-1:0]     addr;
    logic                  write_req;
    logic                  read_req;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [2:0]            size;
    logic                  burstbegin;
    logic [DATA_W-1:0]     rdata;
    logic                  rdata_valid;

    modport master (
        input  ready, rdata, rdata_valid,
        output addr, write_req, read_req, wdata, be, size, burstbegin
    );

    modport slave (
        output ready, rdata, rdata_valid,
        input  addr, write_req, read_req, wdata, be, size, burstbegin
    );

endinterface

// File: rtl/tg_lfsr32.sv
// tg_lfsr32: 32-bit Galois LFSR with synchronous load (priority) and single-step advance.
module tg_lfsr32
    import ddr3_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/ddr3_avl_traffic_gen.sv
// ddr3_avl_traffic_gen: writes an LFSR pattern over a DDR3 word range, reads it back and
// compares. Defining DDR3_TG_ERR_INJECT_EN adds inject_err, which corrupts bit 0 of word 0.
module ddr3_avl_traffic_gen
    import ddr3_tg_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 64,
    parameter int MAX_RD_OUT = 16,
    parameter int CNT_W      = 25
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_base_addr,
    input  logic [CNT_W-1:0]       cfg_num_words,
    input  logic [31:0]            cfg_seed,
`ifdef DDR3_TG_ERR_INJECT_EN
    input  logic                   inject_err,
`endif
    input  logic                   local_init_done,
    input  logic                   local_cal_success,
    input  logic                   local_cal_fail,
    ddr3_avl_traffic_gen_if.master avl,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [ADDR_W-1:0]      first_err_addr
);

    localparam int                   REP     = DATA_W / 32;
    localparam int                   OUT_W   = $clog2(MAX_RD_OUT) + 1;
    localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAX_RD_OUT);
    localparam logic [OUT_W-1:0]     OUT_ONE = OUT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    tg_state_t            state_reg, state_next;
    logic [ADDR_W-1:0]    base_reg, first_err_addr_reg;
    logic [CNT_W-1:0]     num_reg, wr_cnt_reg, rd_issued_reg, rd_ret_reg;
    logic [OUT_W-1:0]     outstanding_reg;
    logic [31:0]          seed_reg, start_seed, lfsr_w, lfsr_r;
    logic [ERR_CNT_W-1:0] err_count_reg;
    logic                 first_err_seen_reg;
    logic [DATA_W-1:0]    wr_pattern, exp_pattern, inj_mask;
    logic                 start_ok, rd_can, wr_acc, rd_acc, wr_last;
    logic                 rv_good, rv_stray, mismatch, rd_last;

    genvar gi;
    for (gi = 0; gi < REP; gi++) begin : g_rep
        assign wr_pattern[gi*32 +: 32]  = lfsr_w;
        assign exp_pattern[gi*32 +: 32] = lfsr_r;
    end

    assign start_seed = (cfg_seed == 32'h0) ? LFSR_SEED_DEFAULT : cfg_seed;
    assign busy       = (state_reg == WAIT_CAL) || (state_reg == WRITE) || (state_reg == READ);
    assign done       = (state_reg == DONE) || (state_reg == FAIL);
    assign pass       = (state_reg == DONE) && (err_count_reg == '0);
    assign start_ok   = start && !busy;

    // Request qualifiers depend only on registers, so a stalled command cannot change.
    assign rd_can   = (state_reg == READ) && (rd_issued_reg < num_reg) && (outstanding_reg < OUT_MAX);
    assign wr_acc   = (state_reg == WRITE) && avl.ready;
    assign rd_acc   = rd_can && avl.ready;
    assign wr_last  = wr_acc && (wr_cnt_reg == num_reg - CNT_ONE);
    assign rv_good  = (state_reg == READ) && avl.rdata_valid && (outstanding_reg != '0);
    assign rv_stray = (state_reg == READ) && avl.rdata_valid && (outstanding_reg == '0);
    assign mismatch = rv_good && (avl.rdata != exp_pattern);
    assign rd_last  = rv_good && (rd_ret_reg == num_reg - CNT_ONE);

`ifdef DDR3_TG_ERR_INJECT_EN
    logic inject_reg;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            inject_reg <= 1'b0;
        end else if (start_ok) begin
            inject_reg <= inject_err;
        end
    end
    assign inj_mask = (inject_reg && (wr_cnt_reg == '0)) ? DATA_W'(1) : '0;
`else
    assign inj_mask = '0;
`endif

    tg_lfsr32 u_lfsr_wr (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .seed  (start_seed),
        .load  (start_ok),
        .step  (wr_acc),
        .value (lfsr_w)
    );

    // Expected-data generator restarts from the test seed as READ is entered.
    tg_lfsr32 u_lfsr_rd (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .seed  (seed_reg),
        .load  (wr_last),
        .step  (rv_good),
        .value (lfsr_r)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        avl.write_req = 1'b0;
        avl.read_req  = 1'b0;
        avl.addr      = '0;
        avl.wdata     = '0;
        case (state_reg)
            IDLE, DONE, FAIL: begin
                if (start) state_next = WAIT_CAL;
            end
            WAIT_CAL: begin
                if (local_cal_fail) state_next = FAIL;
                else if (local_init_done && local_cal_success)
                    state_next = (num_reg == '0) ? DONE : WRITE;
            end
            WRITE: begin
                avl.write_req = 1'b1;
                avl.addr      = base_reg + ADDR_W'(wr_cnt_reg);
                avl.wdata     = wr_pattern ^ inj_mask;
                if (local_cal_fail) state_next = FAIL;
                else if (wr_last)   state_next = READ;
            end
            READ: begin
                avl.read_req = rd_can;
                if (rd_can) avl.addr = base_reg + ADDR_W'(rd_issued_reg);
                if (local_cal_fail) state_next = FAIL;
                else if (rd_last)   state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign avl.be         = '1;
    assign avl.size       = 3'd1;
    assign avl.burstbegin = avl.write_req | avl.read_req;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            base_reg           <= '0;
            num_reg            <= '0;
            seed_reg           <= '0;
            wr_cnt_reg         <= '0;
            rd_issued_reg      <= '0;
            rd_ret_reg         <= '0;
            outstanding_reg    <= '0;
            err_count_reg      <= '0;
            first_err_addr_reg <= '0;
            first_err_seen_reg <= 1'b0;
        end else if (start_ok) begin
            base_reg           <= cfg_base_addr;
            num_reg            <= cfg_num_words;
            seed_reg           <= start_seed;
            wr_cnt_reg         <= '0;
            rd_issued_reg      <= '0;
            rd_ret_reg         <= '0;
            outstanding_reg    <= '0;
            err_count_reg      <= '0;
            first_err_addr_reg <= '0;
            first_err_seen_reg <= 1'b0;
        end else begin
            if (wr_acc)  wr_cnt_reg    <= wr_cnt_reg + CNT_ONE;
            if (rd_acc)  rd_issued_reg <= rd_issued_reg + CNT_ONE;
            if (rv_good) rd_ret_reg    <= rd_ret_reg + CNT_ONE;
            if (rd_acc && !rv_good)      outstanding_reg <= outstanding_reg + OUT_ONE;
            else if (!rd_acc && rv_good) outstanding_reg <= outstanding_reg - OUT_ONE;
            if ((mismatch || rv_stray) && (err_count_reg != ERR_MAX))
                err_count_reg <= err_count_reg + ERR_ONE;
            if (mismatch && !first_err_seen_reg) begin
                first_err_addr_reg <= base_reg + ADDR_W'(rd_ret_reg);
                first_err_seen_reg <= 1'b1;
            end
        end
    end

    assign err_count      = err_count_reg;
    assign first_err_addr = first_err_addr_reg;

endmodule
